// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_arbiter
// Brief    : Shares the single-port framebuffer RAM between display reads,
//            FIFO-buffered pixel writes and a clear-screen sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module fb_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int FB_DEPTH   = 19200
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_disp_i,
    input  logic [ADDR_W-1:0]             disp_addr_i,
    output logic [DATA_W-1:0]             pixel_data_o,
    input  logic                          wr_valid_i,
    output logic                          wr_ready_o,
    input  logic [ADDR_W-1:0]             wr_addr_i,
    input  logic [DATA_W-1:0]             wr_data_i,
    input  logic                          clr_start_i,
    input  logic [DATA_W-1:0]             clr_color_i,
    output logic                          clr_busy_o,
    output logic                          clr_done_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic [ADDR_W-1:0]             ram_addr_o,
    output logic                          ram_we_o,
    output logic [DATA_W-1:0]             ram_wdata_o,
    input  logic [DATA_W-1:0]             ram_rdata_i
);

    localparam int                 c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                 c_ENT_W   = ADDR_W + DATA_W;
    localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [ADDR_W-1:0]  c_LAST    = ADDR_W'(FB_DEPTH - 1);
    localparam logic [ADDR_W-1:0]  c_ADR_ONE = ADDR_W'(1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_DRAIN = 2'd1;
    localparam logic [1:0] c_S_CLEAR = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nx;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [ADDR_W-1:0]   w_clr_cnt_nx;
    logic [DATA_W-1:0]   r_color;
    logic                r_clr_busy;
    logic                r_clr_done;
    logic                r_wr_ready;
    logic                r_disp_q;
    logic [DATA_W-1:0]   r_pixel;

    logic [c_ENT_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W:0]    r_count;
    logic [c_PTR_W:0]    w_count_nx;
    logic [c_ENT_W-1:0]  w_head;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_clr_wr;
    logic                w_clr_last;

    assign w_empty    = (r_count == '0);
    assign w_push     = wr_valid_i && r_wr_ready;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_clr_last = w_clr_wr && (r_clr_cnt == c_LAST);

    // Sequencer next state; display cycles block every RAM write.
    always_comb begin
        w_state_nx   = r_state;
        w_clr_cnt_nx = r_clr_cnt;
        w_pop        = 1'b0;
        w_clr_wr     = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                w_pop = !in_disp_i && !w_empty;
                if (clr_start_i) begin
                    w_state_nx = c_S_DRAIN;
                end
            end
            c_S_DRAIN: begin
                w_pop = !in_disp_i && !w_empty;
                if (w_empty) begin
                    w_state_nx   = c_S_CLEAR;
                    w_clr_cnt_nx = '0;
                end
            end
            c_S_CLEAR: begin
                if (!in_disp_i) begin
                    w_clr_wr = 1'b1;
                    if (r_clr_cnt == c_LAST) begin
                        w_state_nx = c_S_IDLE;
                    end else begin
                        w_clr_cnt_nx = r_clr_cnt + c_ADR_ONE;
                    end
                end
            end
            default: begin
                w_state_nx = c_S_IDLE;
            end
        endcase
    end

    always_comb begin
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (in_disp_i) begin
            ram_addr_o = disp_addr_i;
        end else if (w_pop) begin
            ram_we_o    = 1'b1;
            ram_addr_o  = w_head[c_ENT_W-1:DATA_W];
            ram_wdata_o = w_head[DATA_W-1:0];
        end else if (w_clr_wr) begin
            ram_we_o    = 1'b1;
            ram_addr_o  = r_clr_cnt;
            ram_wdata_o = r_color;
        end
    end

    always_comb begin
        w_count_nx = r_count;
        if (w_push && !w_pop) begin
            w_count_nx = r_count + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nx = r_count - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {wr_addr_i, wr_data_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_nx;
        end
    end

    // Ready is computed from next-cycle occupancy and state so it is exact when registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_S_IDLE;
            r_clr_cnt  <= '0;
            r_color    <= '0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
            r_wr_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_clr_cnt  <= w_clr_cnt_nx;
            r_clr_busy <= (w_state_nx != c_S_IDLE);
            r_clr_done <= w_clr_last;
            r_wr_ready <= (w_count_nx != c_FULL) && (w_state_nx == c_S_IDLE);
            if ((r_state == c_S_IDLE) && clr_start_i) begin
                r_color <= clr_color_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_q <= 1'b0;
            r_pixel  <= '0;
        end else begin
            r_disp_q <= in_disp_i;
            r_pixel  <= r_disp_q ? ram_rdata_i : '0;
        end
    end

    assign pixel_data_o = r_pixel;
    assign wr_ready_o   = r_wr_ready;
    assign clr_busy_o   = r_clr_busy;
    assign clr_done_o   = r_clr_done;
    assign fifo_count_o = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// tb_fb_arbiter: directed and random stimulus, every cycle compared with a
// queue-based model of the arbiter plus a behavioural single-port RAM.
module tb_fb_arbiter;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int FB_DEPTH   = 19200;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_disp_i;
    logic [15:0]       disp_addr_i;
    logic [7:0]        pixel_data_o;
    logic              wr_valid_i;
    logic              wr_ready_o;
    logic [15:0]       wr_addr_i;
    logic [7:0]        wr_data_i;
    logic              clr_start_i;
    logic [7:0]        clr_color_i;
    logic              clr_busy_o;
    logic              clr_done_o;
    logic [CNT_W-1:0]  fifo_count_o;
    logic [15:0]       ram_addr_o;
    logic              ram_we_o;
    logic [7:0]        ram_wdata_o;
    logic [7:0]        ram_rdata_i;

    fb_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .FB_DEPTH(FB_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_disp_i(in_disp_i), .disp_addr_i(disp_addr_i), .pixel_data_o(pixel_data_o),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .clr_start_i(clr_start_i), .clr_color_i(clr_color_i),
        .clr_busy_o(clr_busy_o), .clr_done_o(clr_done_o), .fifo_count_o(fifo_count_o),
        .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i)
    );

    always #10 clk = ~clk;

    bit [7:0] ram [65536];
    always @(posedge clk) begin
        if (ram_we_o) ram[ram_addr_o] <= ram_wdata_o;
        ram_rdata_i <= ram[ram_addr_o];
    end

    typedef struct packed { logic [15:0] a; logic [7:0] d; } ent_t;
    ent_t        q[$];
    bit [7:0]    ref_mem [65536];
    int          m_mode;        // 0 idle, 1 draining writes, 2 clearing
    int          m_cnt;
    logic [7:0]  m_color, m_pix, m_rd;
    bit          m_ready, m_busy, m_done, m_disp_prev;

    int n_checks = 0;
    int n_fail   = 0;
    int mon_busy_wr = 0, mon_disp_wr = 0, mon_done = 0;
    logic        s_we;
    logic [15:0] s_addr;
    logic [7:0]  s_wd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t: timed out waiting for the DUT", nm, $time);
    endtask

    task automatic model_step();
        logic        e_we;
        logic [15:0] e_addr;
        logic [7:0]  e_wd, pix_n;
        bit          push, clrw, was_empty;
        ent_t        e;
        if (!rst_n) begin
            q.delete();
            m_mode = 0; m_cnt = 0; m_color = 0; m_pix = 0; m_rd = 0;
            m_ready = 0; m_busy = 0; m_done = 0; m_disp_prev = 0;
        end
        e_we = 0; e_addr = 0; e_wd = 0;
        if (in_disp_i) begin
            e_addr = disp_addr_i;
        end else if (m_mode != 2 && q.size() > 0) begin
            e_we = 1; e_addr = q[0].a; e_wd = q[0].d;
        end else if (m_mode == 2) begin
            e_we = 1; e_addr = 16'(m_cnt); e_wd = m_color;
        end
        chk("ram_we", ram_we_o, e_we);
        chk("ram_addr", ram_addr_o, e_addr);
        chk("ram_wdata", ram_wdata_o, e_wd);
        chk("pixel", pixel_data_o, m_pix);
        chk("wr_ready", wr_ready_o, m_ready);
        chk("fifo_count", fifo_count_o, q.size());
        chk("clr_busy", clr_busy_o, m_busy);
        chk("clr_done", clr_done_o, m_done);
        s_we = ram_we_o; s_addr = ram_addr_o; s_wd = ram_wdata_o;
        if (ram_we_o && clr_busy_o) mon_busy_wr++;
        if (ram_we_o && in_disp_i) mon_disp_wr++;
        if (clr_done_o) mon_done++;
        if (rst_n) begin
            pix_n = m_disp_prev ? m_rd : 8'h00;
            if (in_disp_i) m_rd = ref_mem[disp_addr_i];
            m_disp_prev = in_disp_i;
            push      = wr_valid_i && m_ready;
            clrw      = e_we && (m_mode == 2);
            was_empty = (q.size() == 0);
            m_done    = clrw && (m_cnt == FB_DEPTH - 1);
            if (e_we) ref_mem[e_addr] = e_wd;
            if (e_we && !clrw) void'(q.pop_front());
            if (push) begin
                e.a = wr_addr_i; e.d = wr_data_i;
                q.push_back(e);
            end
            case (m_mode)
                0: if (clr_start_i) begin m_mode = 1; m_color = clr_color_i; end
                1: if (was_empty) begin m_mode = 2; m_cnt = 0; end
                default: if (clrw) begin
                    if (m_cnt == FB_DEPTH - 1) m_mode = 0;
                    else m_cnt++;
                end
            endcase
            m_busy  = (m_mode != 0);
            m_ready = (q.size() < FIFO_DEPTH) && (m_mode == 0);
            m_pix   = pix_n;
        end
    endtask

    // Inputs change 1 time unit after the rising edge; the model samples mid-cycle.
    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [7:0] d);
        bit ok = 0;
        wr_valid_i = 1; wr_addr_i = a; wr_data_i = d;
        for (int i = 0; i < 64 && !ok; i++) begin
            ok = wr_ready_o;
            cycle();
        end
        wr_valid_i = 0;
        if (!ok) timeout("push");
    endtask

    initial begin
        int  acc, b0, d0, w0, k;
        bit  got;
        rst_n = 0; in_disp_i = 0; disp_addr_i = 0; wr_valid_i = 0;
        wr_addr_i = 0; wr_data_i = 0; clr_start_i = 0; clr_color_i = 0;
        repeat (3) cycle();
        chk("rst_pixel", pixel_data_o, 0);
        chk("rst_ready", wr_ready_o, 0);
        chk("rst_busy", clr_busy_o, 0);
        chk("rst_count", fifo_count_o, 0);
        chk("rst_we", s_we, 0);
        rst_n = 1;
        cycle();
        chk("ready_after_reset", wr_ready_o, 1);

        in_disp_i = 1; disp_addr_i = 16'h0010; cycle();
        in_disp_i = 0; cycle();
        chk("disp_read_blank", pixel_data_o, 8'h00);
        repeat (4) begin cycle(); chk("blank_no_we", s_we, 0); end

        push(16'h0123, 8'h3C);
        cycle();
        chk("single_we", s_we, 1);
        chk("single_addr", s_addr, 16'h0123);
        chk("single_data", s_wd, 8'h3C);
        chk("single_count", fifo_count_o, 0);

        push(16'h0010, 8'hA5);
        cycle();
        in_disp_i = 1; disp_addr_i = 16'h0010; cycle();
        in_disp_i = 0; cycle();
        chk("disp_read_a5", pixel_data_o, 8'hA5);

        in_disp_i = 1; acc = 0; wr_valid_i = 1;
        for (int i = 0; i < 9; i++) begin
            wr_addr_i = 16'h0200 + 16'(i); wr_data_i = 8'h40 + 8'(i);
            disp_addr_i = 16'($urandom);
            acc += int'(wr_ready_o);
            cycle();
        end
        wr_valid_i = 0;
        chk("full_accepted", acc, 8);
        chk("full_count", fifo_count_o, 8);
        chk("full_ready", wr_ready_o, 0);
        in_disp_i = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("drain_we", s_we, 1);
            chk("drain_addr", s_addr, 32'h200 + i);
        end
        chk("drain_empty", fifo_count_o, 0);

        for (int i = 0; i < 3000; i++) begin
            in_disp_i   = 1'($urandom_range(0, 1));
            disp_addr_i = 16'($urandom_range(0, 255));
            wr_valid_i  = 1'($urandom_range(0, 1));
            wr_addr_i   = 16'($urandom_range(0, 255));
            wr_data_i   = 8'($urandom);
            cycle();
        end
        wr_valid_i = 0; in_disp_i = 0;
        repeat (12) cycle();

        in_disp_i = 1;
        push(16'd100, 8'h11); push(16'd200, 8'h22); push(16'd300, 8'h33);
        b0 = mon_busy_wr; d0 = mon_done;
        clr_color_i = 8'hF0; clr_start_i = 1; cycle();
        clr_start_i = 0; cycle(); cycle();
        in_disp_i = 0;
        wr_valid_i = 1; wr_addr_i = 16'd5; wr_data_i = 8'h77; got = 0;
        for (k = 0; k < 25000; k++) begin
            acc = int'(wr_valid_i && wr_ready_o);
            cycle();
            if (acc != 0) begin wr_valid_i = 0; got = 1; end
            if (got && mon_done > d0) break;
        end
        wr_valid_i = 0;
        if (k == 25000) timeout("clear_pending");
        repeat (4) cycle();
        chk("clear_write_count", mon_busy_wr - b0, 19203);
        chk("clear_done_pulses", mon_done - d0, 1);
        chk("clear_busy_low", clr_busy_o, 0);
        chk("clear_ram_0", ram[0], 8'hF0);
        chk("clear_ram_pending", ram[300], 8'hF0);
        chk("clear_ram_last", ram[19199], 8'hF0);
        chk("clear_ram_beyond", ram[19200], 8'h00);
        chk("post_clear_write", ram[5], 8'h77);

        b0 = mon_busy_wr; d0 = mon_done; w0 = mon_disp_wr;
        clr_color_i = 8'h5A; clr_start_i = 1; cycle();
        clr_start_i = 0;
        for (k = 0; k < 45000; k++) begin
            in_disp_i   = 1'((k / 4) % 2);
            disp_addr_i = 16'($urandom);
            cycle();
            if (mon_done > d0) break;
        end
        if (k == 45000) timeout("clear_interleaved");
        in_disp_i = 0;
        repeat (3) cycle();
        chk("inter_write_count", mon_busy_wr - b0, 19200);
        chk("inter_disp_writes", mon_disp_wr - w0, 0);
        chk("inter_done_pulses", mon_done - d0, 1);
        chk("inter_ram", ram[12345], 8'h5A);

        clr_color_i = 8'h3C; clr_start_i = 1; cycle();
        clr_start_i = 0; d0 = mon_done;
        repeat (5000) cycle();
        rst_n = 0; cycle(); cycle();
        chk("abort_pixel", pixel_data_o, 0);
        chk("abort_ready", wr_ready_o, 0);
        chk("abort_busy", clr_busy_o, 0);
        chk("abort_done", clr_done_o, 0);
        chk("abort_count", fifo_count_o, 0);
        chk("abort_we", s_we, 0);
        chk("abort_addr", s_addr, 0);
        rst_n = 1; cycle(); cycle();
        chk("abort_no_done", mon_done - d0, 0);
        chk("abort_ram_head", ram[100], 8'h3C);
        chk("abort_ram_tail", ram[19000], 8'h5A);
        clr_color_i = 8'hC3; clr_start_i = 1; cycle();
        clr_start_i = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            got = s_we;
        end
        if (!got) timeout("restart_clear");
        else begin
            chk("restart_addr", s_addr, 0);
            chk("restart_data", s_wd, 8'hC3);
        end
        repeat (30) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Owns the single-port framebuffer RAM and shares it between the VGA display read path and a GPU/CPU pixel-write requester.
- Display reads have absolute priority while the beam is in the visible area.
- Pixel writes are buffered in a small FIFO and committed to RAM on non-display cycles.
- Includes a clear-screen sequencer that fills the whole framebuffer with one colour, using only non-display cycles.
- Sits between the VGA timing/driver and the framebuffer BRAM, in the 50 MHz domain.

Parameters:
- ADDR_W, 16, framebuffer address width.
- DATA_W, 8, pixel width (green nibble [7:4], blue nibble [3:0]).
- FIFO_DEPTH, 8, write FIFO entries; must be a power of 2, minimum 2.
- FB_DEPTH, 19200, number of framebuffer pixels (160x120) covered by a clear.

Ports:
- clk  in  1  50 MHz system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_disp_i  in  1  beam in visible area; display owns RAM this cycle.
- disp_addr_i  in  ADDR_W  pixel address from VGA timing.
- pixel_data_o  out  DATA_W  registered pixel to VGA driver.
- wr_valid_i  in  1  write request valid.
- wr_ready_o  out  1  write accepted when valid&&ready.
- wr_addr_i  in  ADDR_W  write pixel address.
- wr_data_i  in  DATA_W  write pixel colour.
- clr_start_i  in  1  one-cycle pulse to start a clear.
- clr_color_i  in  DATA_W  clear colour, sampled on accepted clr_start_i.
- clr_busy_o  out  1  clear pending or in progress.
- clr_done_o  out  1  one-cycle pulse when the last clear write is issued.
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  entries held in the FIFO.
- ram_addr_o  out  ADDR_W  RAM address.
- ram_we_o  out  1  RAM write enable.
- ram_wdata_o  out  DATA_W  RAM write data.
- ram_rdata_i  in  DATA_W  RAM read data, synchronous, 1-cycle latency.

Behaviour:
- **Reset values:** pixel_data_o=0, wr_ready_o=0, clr_busy_o=0, clr_done_o=0, fifo_count_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0.
  - FIFO is emptied and the FSM returns to IDLE.
  - Reset mid-clear aborts the clear; no clr_done_o pulse is produced.
- **Display port ownership (combinational mux):**
  - While in_disp_i=1: ram_addr_o=disp_addr_i, ram_we_o=0, regardless of FSM state.
  - pixel_data_o is registered. In the cycle after an in_disp_i=1 cycle it loads ram_rdata_i; otherwise it loads 0.
  - Display read latency is therefore 2 clocks from address to pixel_data_o.
- **Write FIFO:**
  - Push occurs when wr_valid_i && wr_ready_o.
  - wr_ready_o = !full && (state==IDLE), registered so it is 0 in the first cycle after reset.
  - A push into an empty FIFO is not poppable until the next cycle.
  - Simultaneous push and pop is allowed when not full; fifo_count_o is unchanged in that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- **FSM states:**
  - IDLE:
    - On non-display cycles with the FIFO not empty, pop the head: ram_we_o=1, ram_addr_o/ram_wdata_o = head entry.
    - clr_start_i: latch clr_color_i, set clr_busy_o next cycle, go to DRAIN. Pushes in the same cycle are still accepted.
  - DRAIN:
    - No pushes accepted (wr_ready_o=0).
    - The FIFO keeps popping on non-display cycles.
    - When the FIFO is empty, clear the counter to 0 and go to CLEAR.
  - CLEAR:
    - On each non-display cycle: ram_we_o=1, ram_addr_o=counter, ram_wdata_o=latched colour, counter increments.
    - Display cycles stall the counter.
    - When the write at address FB_DEPTH-1 is issued: clr_done_o=1 for that cycle's next clock, clr_busy_o=0, return to IDLE.
- clr_start_i outside IDLE is ignored.
- Ordering guarantee: writes accepted before a clear request land before the clear; writes accepted after the clear land after it.
- With in_disp_i held at 1, no RAM write ever occurs; the FIFO fills, then wr_ready_o=0.
- Counter is ADDR_W bits; FB_DEPTH must be ≤ 2^ADDR_W.

Test Plan:
- **Reset, then display read:** in_disp_i=1, disp_addr_i=0x0010, RAM[0x0010]=0xA5 → pixel_data_o=0xA5 two clocks later. With in_disp_i=0 → pixel_data_o=0x00 and ram_we_o never asserts with the FIFO empty.
- **Single write during blanking:** push (0x0123,0x3C) with in_disp_i=0 → the next cycle shows ram_we_o=1, ram_addr_o=0x0123, ram_wdata_o=0x3C, and fifo_count_o returns to 0.
- **FIFO full:** hold in_disp_i=1 and push 9 writes → 8 accepted, wr_ready_o=0 with fifo_count_o=8. Drop in_disp_i → 8 writes drain in push order on consecutive cycles.
- **Clear with pending writes:** queue 3 writes, pulse clr_start_i with clr_color_i=0xF0 → the 3 writes commit first, then addresses 0..19199 receive 0xF0. clr_done_o pulses once and clr_busy_o falls with it.
- **Clear interleaved with display:** toggle in_disp_i every 4 cycles during a clear → no write ever occurs while in_disp_i=1, and the total number of clear writes is exactly 19200.
- **Reset mid-clear:** assert rst_n=0 at counter≈5000 → all outputs return to reset values, no clr_done_o pulse, and a new clr_start_i restarts from address 0.
